// File: rtl/gray_updown_counter.sv
// -----------------------------------------------------------------------------
// gray_updown_counter
//
// Parametrised up/down Gray-code counter. A binary count is kept internally and
// its Gray image is registered on the same edge, so gray_out and bin_out always
// describe the same count value (no skew between the two views). Intended for
// Gray-coded pointers and position counters that feed clock-domain crossings.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   SATURATE   0: wrap modulo 2**WIDTH, 1: hold at the end value
//   RESET_BIN  binary count loaded by reset
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous, active-high reset
//   enable    in   1      count one step this cycle
//   up_dn     in   1      1 = count up, 0 = count down
//   clear     in   1      synchronous clear to binary 0 (highest priority)
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  binary value for load
//   gray_out  out  WIDTH  registered Gray code of the current count
//   bin_out   out  WIDTH  registered binary count
//   tc        out  1      bin_out is the end value for the current up_dn
//   wrap      out  1      one-cycle pulse: the last step wrapped
//   sat       out  1      the last enabled step was blocked by saturation
// -----------------------------------------------------------------------------
module gray_updown_counter #(
  parameter int                 WIDTH     = 5,
  parameter bit                 SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_BIN = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_sat;

  logic             w_at_end;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_bin_next;
  logic             w_wrap_next;
  logic             w_sat_next;

  // The end value depends on direction: all-ones when counting up, zero when
  // counting down. Stepping from it is exactly the wrap event.
  assign w_at_end = up_dn ? (&r_bin) : ~(|r_bin);
  assign w_step   = up_dn ? (r_bin + ONE) : (r_bin - ONE);

  // Priority: clear > load > enable > hold. Flags default to 0 so they are
  // single-cycle pulses tied to the step that produced them.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    w_sat_next  = 1'b0;
    if (clear) begin
      w_bin_next = '0;
    end else if (load) begin
      w_bin_next = load_val;
    end else if (enable) begin
      if (SATURATE && w_at_end) begin
        w_sat_next = 1'b1;
      end else begin
        w_bin_next  = w_step;
        w_wrap_next = w_at_end;
      end
    end
  end

  // Gray is derived from the next binary value and registered alongside it,
  // so both views update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= RESET_BIN;
      r_gray <= RESET_GRAY;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= bin2gray(w_bin_next);
      r_wrap <= w_wrap_next;
      r_sat  <= w_sat_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign sat      = r_sat;
  assign tc       = w_at_end;

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk5(input string tag,
                      input logic [4:0] ob, input logic [4:0] og,
                      input logic ow, input logic os, input logic ot,
                      input logic [4:0] eb, input logic [4:0] eg,
                      input logic ew, input logic es, input logic et);
    $display("%s: bin=%0d gray=%02h wrap=%0b sat=%0b tc=%0b", tag, ob, og, ow, os, ot);
    check_eq({tag, ".bin"},  32'(ob), 32'(eb));
    check_eq({tag, ".gray"}, 32'(og), 32'(eg));
    check_eq({tag, ".wrap"}, 32'(ow), 32'(ew));
    check_eq({tag, ".sat"},  32'(os), 32'(es));
    check_eq({tag, ".tc"},   32'(ot), 32'(et));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // a: WIDTH=5 wrap mode, RESET_BIN=0
  logic       a_reset, a_enable, a_up_dn, a_clear, a_load;
  logic [4:0] a_load_val, a_gray, a_bin;
  logic       a_tc, a_wrap, a_sat;
  // b: WIDTH=5 saturate mode
  logic       b_reset, b_enable, b_up_dn, b_clear, b_load;
  logic [4:0] b_load_val, b_gray, b_bin;
  logic       b_tc, b_wrap, b_sat;
  // c: WIDTH=5 wrap mode, RESET_BIN=4
  logic       c_reset, c_enable, c_up_dn, c_clear, c_load;
  logic [4:0] c_load_val, c_gray, c_bin;
  logic       c_tc, c_wrap, c_sat;
  // d: WIDTH=8 wrap mode, random traffic
  logic       d_reset, d_enable, d_up_dn, d_clear, d_load;
  logic [7:0] d_load_val, d_gray, d_bin;
  logic       d_tc, d_wrap, d_sat;

  gray_updown_counter #(.WIDTH(5), .SATURATE(1'b0), .RESET_BIN(5'd0)) u_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .up_dn(a_up_dn), .clear(a_clear),
    .load(a_load), .load_val(a_load_val), .gray_out(a_gray), .bin_out(a_bin),
    .tc(a_tc), .wrap(a_wrap), .sat(a_sat));

  gray_updown_counter #(.WIDTH(5), .SATURATE(1'b1), .RESET_BIN(5'd0)) u_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .up_dn(b_up_dn), .clear(b_clear),
    .load(b_load), .load_val(b_load_val), .gray_out(b_gray), .bin_out(b_bin),
    .tc(b_tc), .wrap(b_wrap), .sat(b_sat));

  gray_updown_counter #(.WIDTH(5), .SATURATE(1'b0), .RESET_BIN(5'd4)) u_c (
    .clk(clk), .reset(c_reset), .enable(c_enable), .up_dn(c_up_dn), .clear(c_clear),
    .load(c_load), .load_val(c_load_val), .gray_out(c_gray), .bin_out(c_bin),
    .tc(c_tc), .wrap(c_wrap), .sat(c_sat));

  gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_BIN(8'd0)) u_d (
    .clk(clk), .reset(d_reset), .enable(d_enable), .up_dn(d_up_dn), .clear(d_clear),
    .load(d_load), .load_val(d_load_val), .gray_out(d_gray), .bin_out(d_bin),
    .tc(d_tc), .wrap(d_wrap), .sat(d_sat));

  // Hand-computed vectors for the count-down-from-2 sequence.
  logic [4:0] dn_bin  [4] = '{5'd1, 5'd0, 5'd31, 5'd30};
  logic [4:0] dn_gray [4] = '{5'h01, 5'h00, 5'h10, 5'h11};
  logic       dn_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       dn_tc   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  // First eight Gray codes of the up-count.
  logic [4:0] up_gray [8] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04};

  initial begin
    logic [4:0] eb;
    logic [4:0] eg;
    logic [7:0] m_bin;
    logic [7:0] old_bin;
    logic [7:0] prev_gray;
    logic       step;
    logic       exp_wrap;

    {a_reset, b_reset, c_reset, d_reset} = 4'hF;
    {a_enable, a_clear, a_load} = 3'b000; a_up_dn = 1'b1; a_load_val = '0;
    {b_enable, b_clear, b_load} = 3'b000; b_up_dn = 1'b1; b_load_val = '0;
    {c_enable, c_clear, c_load} = 3'b000; c_up_dn = 1'b1; c_load_val = '0;
    {d_enable, d_clear, d_load} = 3'b000; d_up_dn = 1'b1; d_load_val = '0;

    tick;
    chk5("reset_a", a_bin, a_gray, a_wrap, a_sat, a_tc, 5'd0, 5'h00, 1'b0, 1'b0, 1'b0);
    chk5("reset_c", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd4, 5'h06, 1'b0, 1'b0, 1'b0);
    {a_reset, b_reset, c_reset, d_reset} = 4'h0;

    // Free-running up-count through one wrap.
    a_enable = 1'b1;
    a_up_dn  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      eb = 5'(k % 32);
      eg = (eb < 8) ? up_gray[eb] : (eb ^ (eb >> 1));
      chk5($sformatf("up[%0d]", k), a_bin, a_gray, a_wrap, a_sat, a_tc,
           eb, eg, (k == 32), 1'b0, (eb == 5'd31));
    end

    // Load 2, then count down through zero.
    a_enable = 1'b0; a_load = 1'b1; a_load_val = 5'd2;
    tick;
    chk5("load2", a_bin, a_gray, a_wrap, a_sat, a_tc, 5'd2, 5'h03, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_enable = 1'b1; a_up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk5($sformatf("dn[%0d]", k), a_bin, a_gray, a_wrap, a_sat, a_tc,
           dn_bin[k], dn_gray[k], dn_wrap[k], 1'b0, dn_tc[k]);
    end

    // clear beats load beats enable.
    a_clear = 1'b1; a_load = 1'b1; a_load_val = 5'd9; a_enable = 1'b1;
    tick;
    chk5("clr_prio", a_bin, a_gray, a_wrap, a_sat, a_tc, 5'd0, 5'h00, 1'b0, 1'b0, 1'b1);
    a_clear = 1'b0;
    tick;
    chk5("load_prio", a_bin, a_gray, a_wrap, a_sat, a_tc, 5'd9, 5'h0D, 1'b0, 1'b0, 1'b0);
    a_load = 1'b0; a_enable = 1'b0;
    tick;
    chk5("hold", a_bin, a_gray, a_wrap, a_sat, a_tc, 5'd9, 5'h0D, 1'b0, 1'b0, 1'b0);

    // Saturating instance.
    b_load = 1'b1; b_load_val = 5'd31;
    tick;
    chk5("sat_load", b_bin, b_gray, b_wrap, b_sat, b_tc, 5'd31, 5'h10, 1'b0, 1'b0, 1'b1);
    b_load = 1'b0; b_enable = 1'b1; b_up_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk5($sformatf("sat_up[%0d]", k), b_bin, b_gray, b_wrap, b_sat, b_tc,
           5'd31, 5'h10, 1'b0, 1'b1, 1'b1);
    end
    b_up_dn = 1'b0;
    tick;
    chk5("sat_dn", b_bin, b_gray, b_wrap, b_sat, b_tc, 5'd30, 5'h11, 1'b0, 1'b0, 1'b0);
    b_enable = 1'b0;
    tick;
    chk5("sat_idle", b_bin, b_gray, b_wrap, b_sat, b_tc, 5'd30, 5'h11, 1'b0, 1'b0, 1'b0);
    b_load = 1'b1; b_load_val = 5'd0;
    tick;
    b_load = 1'b0; b_enable = 1'b1;
    tick;
    chk5("sat_zero", b_bin, b_gray, b_wrap, b_sat, b_tc, 5'd0, 5'h00, 1'b0, 1'b1, 1'b1);
    b_enable = 1'b0;

    // Asynchronous reset mid-cycle on the RESET_BIN=4 instance.
    c_load = 1'b1; c_load_val = 5'd17;
    tick;
    chk5("c_load17", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd17, 5'h19, 1'b0, 1'b0, 1'b0);
    c_load = 1'b0; c_enable = 1'b1; c_up_dn = 1'b1;
    #3 c_reset = 1'b1;
    #1;
    chk5("c_async", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd4, 5'h06, 1'b0, 1'b0, 1'b0);
    tick;
    chk5("c_held", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd4, 5'h06, 1'b0, 1'b0, 1'b0);
    c_reset = 1'b0;
    tick;
    chk5("c_resume5", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd5, 5'h07, 1'b0, 1'b0, 1'b0);
    tick;
    chk5("c_resume6", c_bin, c_gray, c_wrap, c_sat, c_tc, 5'd6, 5'h05, 1'b0, 1'b0, 1'b0);
    c_enable = 1'b0;

    // Random traffic on the 8-bit instance.
    m_bin = 8'd0;
    for (int n = 0; n < 10000; n++) begin
      d_enable   = ($urandom_range(0, 3) != 0);
      d_up_dn    = 1'($urandom_range(0, 1));
      d_load     = ($urandom_range(0, 15) == 0);
      d_clear    = ($urandom_range(0, 63) == 0);
      d_load_val = 8'($urandom_range(0, 255));
      prev_gray  = d_gray;
      old_bin    = m_bin;
      step       = d_enable && !d_load && !d_clear;
      exp_wrap   = step && ((d_up_dn && old_bin == 8'hFF) || (!d_up_dn && old_bin == 8'h00));
      if (d_clear)      m_bin = 8'd0;
      else if (d_load)  m_bin = d_load_val;
      else if (d_enable) m_bin = d_up_dn ? old_bin + 8'd1 : old_bin - 8'd1;
      tick;
      check_eq("rnd.bin",  32'(d_bin), 32'(m_bin));
      check_eq("rnd.gray", 32'(d_gray), 32'(d_bin ^ (d_bin >> 1)));
      check_eq("rnd.wrap", 32'(d_wrap), 32'(exp_wrap));
      if (step) check_eq("rnd.hamming", 32'($countones(prev_gray ^ d_gray)), 32'd1);
    end
    $display("random: 10000 cycles on 8-bit counter, %0d errors so far", errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
